serv_alu_seq: RTL
=================

# serv_alu_seq

Phase sequencer for the bit-serial ALU. Accepts a one-cycle start request, then generates the per-bit enable, init-phase flag, shift-amount load enable, bit counter and last-bit strobe that the serial ALU consumes. It also sequences the optional init phase, waits for shift completion, and reports completion. It sits directly upstream of the ALU, between instruction decode and the serial datapath.

## Interface
- `WIDTH`, 32, serial word length in bits; power of two, 8..32; one bit per enabled cycle
- `clk` in 1 — clock, all state on rising edge
- `i_rst_n` in 1 — synchronous active-low reset
- `i_start` in 1 — start request, sampled only in IDLE
- `i_two_stage` in 1 — operation needs an init phase (compare, shift); sampled with `i_start`
- `i_shift_op` in 1 — operation is a shift; sampled with `i_start`; ignored unless `i_two_stage`
- `i_sh_done` in 1 — shifter finished, from ALU
- `o_busy` out 1 — state != IDLE
- `o_en` out 1 — ALU bit enable
- `o_init` out 1 — init phase active
- `o_shamt_en` out 1 — shift-amount register load enable
- `o_cnt` out $clog2(WIDTH) — current bit index
- `o_cnt_done` out 1 — last bit of current phase
- `o_rd_en` out 1 — destination write enable (run phase bits)
- `o_done` out 1 — one-cycle completion pulse

## Operation
- States: IDLE, INIT, GAP, SH_WAIT, RUN
- IDLE + `i_start`: latch `i_two_stage`, `i_shift_op` → INIT if two_stage, else RUN; cnt ← 0
- INIT: `o_en`=`o_init`=1; cnt increments. At cnt==WIDTH-1 → GAP, cnt ← 0
- GAP: all enables 0, exactly one cycle; → SH_WAIT if shift latched, else RUN
  - Required so the ALU's first-bit detection (rising `o_en`) re-arms for the run phase
- SH_WAIT: enables 0; cnt holds 0; when `i_sh_done`=1 → RUN next cycle
- RUN: `o_en`=`o_rd_en`=1; cnt increments. At cnt==WIDTH-1 → IDLE, cnt ← 0, `o_done`=1 in the following cycle
- `o_shamt_en` = INIT & shift latched & cnt<5
- `o_cnt_done` = (INIT|RUN) & cnt==WIDTH-1; combinational from registered state/cnt
- `o_cnt` wraps modulo WIDTH; never observed ≥ WIDTH
- `i_start` while busy: ignored, no queueing
- `i_sh_done` outside SH_WAIT: ignored
- Reset (any state, including mid-phase): → IDLE; cnt=0; all outputs 0 next cycle. Reset wins over simultaneous `i_start`.

## Timing
- All outputs registered or decoded from registered state; none depend combinationally on inputs
- Reset values: `o_busy`, `o_en`, `o_init`, `o_shamt_en`, `o_cnt_done`, `o_rd_en`, `o_done` = 0; `o_cnt`=0
- `i_start` at cycle 0:
  - Single-stage: RUN cycles 1..WIDTH; `o_done` at WIDTH+1
  - Two-stage non-shift: INIT 1..WIDTH, GAP WIDTH+1, RUN WIDTH+2..2·WIDTH+1; `o_done` at 2·WIDTH+2
  - Shift: INIT 1..WIDTH, GAP WIDTH+1, SH_WAIT from WIDTH+2 (minimum one cycle); RUN starts the cycle after `i_sh_done` is sampled high
- `o_done` cycle is an IDLE cycle: `i_start` accepted there (back-to-back, zero bubble)

## Configuration
- `SERV_ALU_SEQ_SH_TIMEOUT_EN` defined:
  - Adds output `o_sh_timeout` (1 bit, reset 0)
  - SH_WAIT counts cycles; if `i_sh_done` is not seen within WIDTH cycles, force → RUN and pulse `o_sh_timeout` for one cycle, coincident with the transition
- Undefined: port absent; SH_WAIT waits indefinitely

## Test plan
- Reset: hold `i_rst_n`=0 with `i_start`=1 for 3 cycles → all outputs 0, `o_busy`=0; release → IDLE
- Single-stage, WIDTH=32, start at cycle 0 → `o_en`/`o_rd_en` high cycles 1..32; `o_cnt_done` at cycle 32 only; `o_done` at 33; start at 33 accepted
- Two-stage compare → `o_init` cycles 1..32; `o_en`=0 at 33; RUN 34..65; `o_done` at 66; `o_shamt_en` never high
- Shift with `i_sh_done` high at cycle 40 → `o_shamt_en` cycles 1..5; SH_WAIT 34..40; RUN 41..72; `o_done` at 73
- `i_start` pulses during INIT and RUN → ignored; reset at RUN cnt=10 → IDLE, `o_done` never pulses
- With `SERV_ALU_SEQ_SH_TIMEOUT_EN`, shift, `i_sh_done` held 0 → `o_sh_timeout` pulses once after 32 SH_WAIT cycles; RUN follows; `o_done` 32 cycles later

Source files
------------

// File: rtl/serv_alu_seq.sv
// serv_alu_seq -- phase sequencer for the bit-serial ALU.
// Accepts a one-cycle start, then walks the optional init phase, a one-cycle
// gap, an optional wait for the shifter and the run phase, producing the
// per-bit enables, bit counter and last-bit strobe consumed by the serial ALU.
// Optional feature: define SERV_ALU_SEQ_SH_TIMEOUT_EN to bound the shifter
// wait to WIDTH cycles and add the o_sh_timeout output.

module serv_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_two_stage,
  input  logic                     i_shift_op,
  input  logic                     i_sh_done,
  output logic                     o_busy,
  output logic                     o_en,
  output logic                     o_init,
  output logic                     o_shamt_en,
  output logic [$clog2(WIDTH)-1:0] o_cnt,
  output logic                     o_cnt_done,
  output logic                     o_rd_en,
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
  output logic                     o_sh_timeout,
`endif
  output logic                     o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_GAP,
    S_SH_WAIT,
    S_RUN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          shift_q;   // latched "operation is a shift" (only with two-stage)
  logic          done_q;

`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
  logic [CW-1:0] wait_cnt;  // SH_WAIT cycles elapsed, minus one
  logic          sh_timeout_q;
`endif

  // Phase FSM, bit counter and registered completion pulse.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
      wait_cnt     <= '0;
      sh_timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
      sh_timeout_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            shift_q <= i_two_stage & i_shift_op;
            cnt     <= '0;
            state   <= i_two_stage ? S_INIT : S_RUN;
          end
        end
        S_INIT: begin
          // Counter width equals log2(WIDTH), so the increment wraps to 0
          // on the last bit without an explicit clear.
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          // One dead cycle drops o_en so the ALU re-detects the first bit.
          state <= shift_q ? S_SH_WAIT : S_RUN;
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_SH_WAIT: begin
          if (i_sh_done) begin
            state <= S_RUN;
          end
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
          else if (wait_cnt == LAST) begin
            state        <= S_RUN;
            sh_timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state and counter only.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    o_busy     = 1'b0;
    o_en       = 1'b0;
    o_init     = 1'b0;
    o_shamt_en = 1'b0;
    o_cnt_done = 1'b0;
    o_rd_en    = 1'b0;
    case (state)
      S_INIT: begin
        o_busy     = 1'b1;
        o_en       = 1'b1;
        o_init     = 1'b1;
        o_shamt_en = shift_q && (int'(cnt) < 5);
        o_cnt_done = (cnt == LAST);
      end
      S_GAP, S_SH_WAIT: begin
        o_busy = 1'b1;
      end
      S_RUN: begin
        o_busy     = 1'b1;
        o_en       = 1'b1;
        o_rd_en    = 1'b1;
        o_cnt_done = (cnt == LAST);
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_cnt  = cnt;
  assign o_done = done_q;
`ifdef SERV_ALU_SEQ_SH_TIMEOUT_EN
  assign o_sh_timeout = sh_timeout_q;
`endif

endmodule
